cmn_onehot2bin_pipe: RTL and testbench
======================================

// Module: cmn_onehot2bin_pipe
// PURPOSE
//  Multi-lane, pipelined onehot-to-binary encoder with a valid/ready stream interface.
//  Each beat carries NUM_CH onehot vectors. Each lane is encoded to a binary index
//  plus hit/multi-hot flags, and the result is registered behind a 2-entry skid buffer.
//  A saturating counter tracks malformed (multi-hot) beats.
//  Drop-in successor to the combinational encoder for arbiter-grant and way-select paths
//  that need a registered, back-pressurable result.
// PARAMETERS
//  ONEHOT_WIDTH  8   bits per lane onehot vector (>=1)
//  NUM_CH        4   number of independent lanes per beat (>=1)
//  MSB_PRIO      1   multi-hot resolution: 1 = highest set bit wins (legacy), 0 = lowest wins
//  ERR_CNT_W     16  width of the multi-hot error counter
//  BIN_WIDTH     localparam = max(1,$clog2(ONEHOT_WIDTH))
// PORTS
//  clk        in   1                      clock
//  rst_n      in   1                      async active-low reset
//  in_valid   in   1                      input beat valid
//  in_ready   out  1                      input beat accepted when in_valid&&in_ready
//  onehot_in  in   NUM_CH*ONEHOT_WIDTH    lane c = onehot_in[c*ONEHOT_WIDTH +: ONEHOT_WIDTH]
//  out_valid  out  1                      output beat valid
//  out_ready  in   1                      downstream accept
//  bin_out    out  NUM_CH*BIN_WIDTH       lane c encoded index
//  hit_out    out  NUM_CH                 lane c had >=1 bit set
//  multi_out  out  NUM_CH                 lane c had >=2 bits set
//  err_clr    in   1                      synchronous clear of err_cnt
//  err_cnt    out  ERR_CNT_W              accepted beats with any multi_out lane, saturating
// BEHAVIOUR
//  - Reset (async assert, sync deassert via clk): out_valid=0, bin_out/hit_out/multi_out=0,
//    err_cnt=0, skid empty, so in_ready=1. Reset mid-stream discards all in-flight beats.
//  - Per-lane encode (combinational, pre-register):
//    - zero-hot: bin={BIN_WIDTH{1}}, hit=0, multi=0.
//    - onehot: bin=index, hit=1, multi=0.
//    - multi-hot: bin=index of highest (MSB_PRIO=1) or lowest (MSB_PRIO=0) set bit, hit=1, multi=1.
//    - Consumers use hit_out, not bin value, to distinguish zero-hot from top index.
//  - Pipeline: main output register + 1 skid register. in_ready = ~skid_valid (registered,
//    no combinational path from out_ready).
//    - Accepted beat appears on outputs the next cycle if the main reg is empty or draining.
//    - Latency 1 cycle; throughput 1 beat/cycle while out_ready=1.
//    - Stall: out_ready=0 with main valid, new beat accepted -> beat goes to skid,
//      in_ready drops next cycle.
//    - On out_ready, skid moves to main and in_ready rises the following cycle.
//    - Outputs hold stable while out_valid&&!out_ready. Beat order is strictly preserved.
//    - No beat is dropped or duplicated.
//  - err_cnt increments by 1 on each accepted beat with any lane multi-hot.
//    - Holds at 2^ERR_CNT_W-1.
//    - err_clr wins over a same-cycle increment (result 0).
// STRUCTURE
//  - Package cmn_onehot2bin_pkg: function safe_clog2(int) (min 1);
//    typedef enum {PRIO_LSB, PRIO_MSB} prio_e.
//  - Sub-module cmn_onehot2bin_lane: combinational single-lane encoder
//    (onehot -> bin, hit, multi; MSB_PRIO param).
//  - Top instantiates NUM_CH lanes via generate and owns the skid pipeline and counter.
// TESTING (ONEHOT_WIDTH=8, NUM_CH=4)
//  1. Reset then lanes {0x01,0x80,0x10,0x00}, out_ready=1 -> next cycle bin={0,7,4,7},
//     hit=4'b0111, multi=0, out_valid=1.
//  2. Lane0=0x22, MSB_PRIO=1 -> bin0=5, multi0=1, err_cnt=1.
//     Same beat with MSB_PRIO=0 build -> bin0=1.
//  3. Stream 3 beats, out_ready=0 from beat 2:
//     - in_ready=0 after beat 3 is accepted into skid; outputs hold beat 2.
//     - Release out_ready -> beats 2,3 emerge in order, in_ready returns 1.
//  4. Random valid/ready toggling, 10k beats vs reference model -> exact sequence match,
//     no loss or duplication.
//  5. ERR_CNT_W=2: 5 multi-hot beats -> err_cnt saturates at 3.
//     err_clr with a concurrent multi-hot beat -> 0.
//  6. Assert rst_n with beats in main and skid -> out_valid=0, in_ready=1, err_cnt=0
//     immediately (async).
//     ONEHOT_WIDTH=1 build: 0x1 -> bin=0, hit=1; 0x0 -> bin=1, hit=0.

Source files
------------

// File: rtl/cmn_onehot2bin_pkg.sv
// cmn_onehot2bin_pkg: shared types and helpers for the onehot-to-binary encoder
package cmn_onehot2bin_pkg;
  typedef enum logic {PRIO_LSB, PRIO_MSB} prio_e;
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cmn_onehot2bin_lane.sv
// cmn_onehot2bin_lane: combinational single-lane onehot-to-binary encoder
module cmn_onehot2bin_lane
  import cmn_onehot2bin_pkg::*;
#(
  parameter int W        = 8,
  parameter int MSB_PRIO = 1,
  parameter int BW       = safe_clog2(W)
) (
  input  logic [W-1:0]  onehot,
  output logic [BW-1:0] bin,
  output logic          hit,
  output logic          multi
);
  localparam prio_e PRIO = (MSB_PRIO != 0) ? PRIO_MSB : PRIO_LSB;
  // scan from lowest to highest priority so the last set bit seen wins; zero-hot keeps all-ones
  always_comb begin
    bin = '1;
    for (int i = 0; i < W; i++) begin
      if (onehot[(PRIO == PRIO_MSB) ? i : W - 1 - i]) bin = BW'((PRIO == PRIO_MSB) ? i : W - 1 - i);
    end
    hit = |onehot;
    multi = |(onehot & (onehot - 1'b1));
  end
endmodule

// File: rtl/cmn_onehot2bin_pipe.sv
// cmn_onehot2bin_pipe: multi-lane onehot-to-binary encoder behind a 2-entry skid buffer
module cmn_onehot2bin_pipe
  import cmn_onehot2bin_pkg::*;
#(
  parameter  int ONEHOT_WIDTH = 8,
  parameter  int NUM_CH       = 4,
  parameter  int MSB_PRIO     = 1,
  parameter  int ERR_CNT_W    = 16,
  localparam int BIN_WIDTH    = safe_clog2(ONEHOT_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CH*ONEHOT_WIDTH-1:0] onehot_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CH*BIN_WIDTH-1:0]    bin_out,
  output logic [NUM_CH-1:0]              hit_out,
  output logic [NUM_CH-1:0]              multi_out,
  input  logic                           err_clr,
  output logic [ERR_CNT_W-1:0]           err_cnt
);
  localparam int DW = NUM_CH * (BIN_WIDTH + 2);
  logic [NUM_CH*BIN_WIDTH-1:0] enc_bin;
  logic [NUM_CH-1:0]           enc_hit;
  logic [NUM_CH-1:0]           enc_multi;
  logic [DW-1:0]               enc;
  logic                        main_valid_q, main_valid_d;
  logic                        skid_valid_q, skid_valid_d;
  logic [DW-1:0]               main_data_q, main_data_d;
  logic [DW-1:0]               skid_data_q, skid_data_d;
  logic [ERR_CNT_W-1:0]        err_cnt_q, err_cnt_d;
  logic                        accept, main_load, err_inc;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    cmn_onehot2bin_lane #(
      .W        (ONEHOT_WIDTH),
      .MSB_PRIO (MSB_PRIO),
      .BW       (BIN_WIDTH)
    ) u_lane (
      .onehot (onehot_in[c*ONEHOT_WIDTH +: ONEHOT_WIDTH]),
      .bin    (enc_bin[c*BIN_WIDTH +: BIN_WIDTH]),
      .hit    (enc_hit[c]),
      .multi  (enc_multi[c])
    );
  end

  assign enc       = {enc_multi, enc_hit, enc_bin};
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign err_cnt   = err_cnt_q;
  assign {multi_out, hit_out, bin_out} = main_data_q;

  // main reg refills from skid first (older beat) whenever it is empty or draining; skid only catches a stalled accept
  always_comb begin
    accept = in_valid & in_ready;
    main_load = ~main_valid_q | out_ready;
    main_valid_d = main_load ? (skid_valid_q | accept) : main_valid_q;
    main_data_d = main_load ? (skid_valid_q ? skid_data_q : (accept ? enc : main_data_q)) : main_data_q;
    skid_valid_d = main_load ? 1'b0 : (skid_valid_q | accept);
    skid_data_d = (~main_load & accept) ? enc : skid_data_q;
    err_inc = accept & (|enc_multi);
    err_cnt_d = err_clr ? '0 : ((err_inc && err_cnt_q != {ERR_CNT_W{1'b1}}) ? err_cnt_q + 1'b1 : err_cnt_q);
  end

  // pipeline and error counter state; reset empties both stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      err_cnt_q    <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_cmn_onehot2bin_pipe.sv
// tb_cmn_onehot2bin_pipe: table vectors, stall/reset sequences and a random scoreboard run
module tb_cmn_onehot2bin_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] onehot_in = '0;
  logic        w1_in = 1'b0;
  logic        in_ready, out_valid;
  logic [11:0] bin_out;
  logic [3:0]  hit_out, multi_out;
  logic [15:0] err_cnt;
  logic        lsb_in_ready, lsb_out_valid;
  logic [11:0] lsb_bin;
  logic [3:0]  lsb_hit, lsb_multi;
  logic [1:0]  lsb_err;
  logic        w1_in_ready, w1_out_valid, w1_bin, w1_hit, w1_multi;
  logic [15:0] w1_err;
  int          n_total = 0;
  int          n_bad = 0;

  typedef struct {
    logic [11:0] bin;
    logic [11:0] bin_l;
    logic [3:0]  hit;
    logic [3:0]  multi;
    logic        w1_bin;
    logic        w1_hit;
  } exp_t;

  typedef struct {
    logic [31:0] oh;
    logic        w1;
    logic [11:0] bin;
    logic [11:0] bin_l;
    logic [3:0]  hit;
    logic [3:0]  multi;
    logic [15:0] err;
    logic        w1_bin;
    logic        w1_hit;
  } vec_t;

  exp_t        q[$];
  logic [15:0] exp_err = '0;
  logic [1:0]  exp_err2 = '0;

  always #5 clk = ~clk;

  cmn_onehot2bin_pipe #(.ONEHOT_WIDTH(8), .NUM_CH(4), .MSB_PRIO(1), .ERR_CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .onehot_in(onehot_in),
    .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out), .hit_out(hit_out),
    .multi_out(multi_out), .err_clr(err_clr), .err_cnt(err_cnt));

  cmn_onehot2bin_pipe #(.ONEHOT_WIDTH(8), .NUM_CH(4), .MSB_PRIO(0), .ERR_CNT_W(2)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(lsb_in_ready), .onehot_in(onehot_in),
    .out_valid(lsb_out_valid), .out_ready(out_ready), .bin_out(lsb_bin), .hit_out(lsb_hit),
    .multi_out(lsb_multi), .err_clr(err_clr), .err_cnt(lsb_err));

  cmn_onehot2bin_pipe #(.ONEHOT_WIDTH(1), .NUM_CH(1), .MSB_PRIO(1), .ERR_CNT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w1_in_ready), .onehot_in(w1_in),
    .out_valid(w1_out_valid), .out_ready(out_ready), .bin_out(w1_bin), .hit_out(w1_hit),
    .multi_out(w1_multi), .err_clr(err_clr), .err_cnt(w1_err));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [2:0] lane_ref(input logic [7:0] v, input bit msb);
    if (v == 8'h00) return 3'd7;
    if (msb) begin
      for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
    end else begin
      for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  function automatic exp_t model(input logic [31:0] oh, input logic w1);
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      e.bin[c*3 +: 3]   = lane_ref(oh[c*8 +: 8], 1'b1);
      e.bin_l[c*3 +: 3] = lane_ref(oh[c*8 +: 8], 1'b0);
      e.hit[c]          = $countones(oh[c*8 +: 8]) >= 1;
      e.multi[c]        = $countones(oh[c*8 +: 8]) >= 2;
    end
    e.w1_bin = ~w1;
    e.w1_hit = w1;
    return e;
  endfunction

  function automatic logic [31:0] rand_oh();
    logic [31:0] v;
    for (int c = 0; c < 4; c++) begin
      case ($urandom_range(0, 2))
        0:       v[c*8 +: 8] = 8'h00;
        1:       v[c*8 +: 8] = 8'(1 << $urandom_range(0, 7));
        default: v[c*8 +: 8] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: pop on delivered beats, track expected error counters, push on accepted beats
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      exp_t n;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL sb_extra: beat delivered with nothing expected at %0t", $time);
        end else begin
          e = q.pop_front();
          check("sb_bin", {20'h0, bin_out}, {20'h0, e.bin});
          check("sb_hit", {28'h0, hit_out}, {28'h0, e.hit});
          check("sb_multi", {28'h0, multi_out}, {28'h0, e.multi});
          check("sb_lsb_bin", {20'h0, lsb_bin}, {20'h0, e.bin_l});
          check("sb_lsb_valid", {31'h0, lsb_out_valid}, 32'h1);
          check("sb_w1", {28'h0, w1_out_valid, w1_bin, w1_hit, w1_multi}, {28'h0, 1'b1, e.w1_bin, e.w1_hit, 1'b0});
        end
      end
      check("sb_err", {16'h0, err_cnt}, {16'h0, exp_err});
      check("sb_err2", {30'h0, lsb_err}, {30'h0, exp_err2});
      n = model(onehot_in, w1_in);
      if (err_clr) begin
        exp_err = '0;
        exp_err2 = '0;
      end else if (in_valid && in_ready && n.multi != 4'h0) begin
        if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        if (exp_err2 != 2'd3) exp_err2 = exp_err2 + 2'd1;
      end
      if (in_valid && in_ready) q.push_back(n);
    end
  end

  initial begin
    vec_t tbl[4];
    int beats;
    tbl[0] = '{32'h0010_8001, 1'b1, {3'd7, 3'd4, 3'd7, 3'd0}, {3'd7, 3'd4, 3'd7, 3'd0}, 4'b0111, 4'b0000, 16'd0, 1'b0, 1'b1};
    tbl[1] = '{32'h0000_0022, 1'b0, {3'd7, 3'd7, 3'd7, 3'd5}, {3'd7, 3'd7, 3'd7, 3'd1}, 4'b0001, 4'b0001, 16'd1, 1'b1, 1'b0};
    tbl[2] = '{32'h400C_81FF, 1'b1, {3'd6, 3'd3, 3'd7, 3'd7}, {3'd6, 3'd2, 3'd0, 3'd0}, 4'b1111, 4'b0111, 16'd2, 1'b0, 1'b1};
    tbl[3] = '{32'h2008_0402, 1'b0, {3'd5, 3'd3, 3'd2, 3'd1}, {3'd5, 3'd3, 3'd2, 3'd1}, 4'b1111, 4'b0000, 16'd2, 1'b1, 1'b0};

    repeat (2) tick();
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_data", {8'h0, bin_out, hit_out, multi_out}, 32'h0);
    check("rst_err", {16'h0, err_cnt}, 32'h0);
    rst_n = 1'b1;
    tick();

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      onehot_in = tbl[i].oh;
      w1_in = tbl[i].w1;
      tick();
      in_valid = 1'b0;
      check("tbl_valid", {31'h0, out_valid}, 32'h1);
      check("tbl_bin", {20'h0, bin_out}, {20'h0, tbl[i].bin});
      check("tbl_hit", {28'h0, hit_out}, {28'h0, tbl[i].hit});
      check("tbl_multi", {28'h0, multi_out}, {28'h0, tbl[i].multi});
      check("tbl_lsb_bin", {20'h0, lsb_bin}, {20'h0, tbl[i].bin_l});
      check("tbl_err", {16'h0, err_cnt}, {16'h0, tbl[i].err});
      check("tbl_w1", {30'h0, w1_bin, w1_hit}, {30'h0, tbl[i].w1_bin, tbl[i].w1_hit});
    end
    tick();
    check("tbl_idle", {31'h0, out_valid}, 32'h0);

    in_valid = 1'b1;
    onehot_in = 32'h0101_0101;
    tick();
    onehot_in = 32'h0202_0202;
    tick();
    out_ready = 1'b0;
    onehot_in = 32'h4040_4040;
    tick();
    in_valid = 1'b0;
    check("stall_in_ready", {31'h0, in_ready}, 32'h0);
    check("stall_bin", {20'h0, bin_out}, 32'h249);
    tick();
    check("hold_valid", {31'h0, out_valid}, 32'h1);
    check("hold_bin", {20'h0, bin_out}, 32'h249);
    check("hold_in_ready", {31'h0, in_ready}, 32'h0);
    out_ready = 1'b1;
    tick();
    check("skid_bin", {20'h0, bin_out}, 32'hDB6);
    check("skid_in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    check("skid_done", {31'h0, out_valid}, 32'h0);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    in_valid = 1'b1;
    onehot_in = 32'h0303_0303;
    repeat (5) tick();
    in_valid = 1'b0;
    check("sat_err2", {30'h0, lsb_err}, 32'h3);
    check("sat_err16", {16'h0, err_cnt}, 32'h5);
    in_valid = 1'b1;
    err_clr = 1'b1;
    tick();
    in_valid = 1'b0;
    err_clr = 1'b0;
    check("clr_err2", {30'h0, lsb_err}, 32'h0);
    check("clr_err16", {16'h0, err_cnt}, 32'h0);
    repeat (2) tick();

    beats = 0;
    for (int cyc = 0; cyc < 60000 && beats < 10000; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      onehot_in = rand_oh();
      w1_in = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) beats++;
      tick();
    end
    check("rand_beats", beats, 10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    tick();
    check("rand_drained", q.size(), 0);
    check("rand_idle", {31'h0, out_valid}, 32'h0);

    out_ready = 1'b0;
    in_valid = 1'b1;
    onehot_in = 32'h0000_0003;
    tick();
    onehot_in = 32'h0000_0300;
    tick();
    in_valid = 1'b0;
    check("pre_rst_full", {30'h0, out_valid, in_ready}, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'h0, out_valid}, 32'h0);
    check("arst_in_ready", {31'h0, in_ready}, 32'h1);
    check("arst_err", {16'h0, err_cnt}, 32'h0);
    check("arst_err2", {30'h0, lsb_err}, 32'h0);
    q.delete();
    exp_err = '0;
    exp_err2 = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) tick();
    check("post_rst_idle", {31'h0, out_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
